// File: rtl/stack_seq_pkg.sv
// stack_seq_pkg: opcodes, top-offset encodings, FSM state encodings and
// per-opcode rules shared by the sequencer and its decoder.
package stack_seq_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_PUSH = 4'd1,
    OP_DROP = 4'd2,
    OP_DUP  = 4'd3,
    OP_SWAP = 4'd4,
    OP_OVER = 4'd5,
    OP_NIP  = 4'd6,
    OP_REPL = 4'd7,
    OP_BIN  = 4'd8
  } op_e;

  // Signed 2-bit top delta; 2'b10 is never produced.
  localparam logic [1:0] OFF_PUSH = 2'b01;
  localparam logic [1:0] OFF_NONE = 2'b00;
  localparam logic [1:0] OFF_POP  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_SWAP2 = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'(OP_BIN);
  endfunction

  // Elements a word needs on the stack before it may run.
  function automatic logic [1:0] op_min_depth(input logic [3:0] op);
    case (op)
      OP_DROP, OP_DUP, OP_REPL:        return 2'd1;
      OP_SWAP, OP_OVER, OP_NIP, OP_BIN: return 2'd2;
      default:                          return 2'd0;
    endcase
  endfunction

  // Words that add an element and so need a free slot.
  function automatic logic op_grows(input logic [3:0] op);
    return (op == OP_PUSH) || (op == OP_DUP) || (op == OP_OVER);
  endfunction

  // Net change of the top pointer when the word commits.
  function automatic logic [1:0] op_offset(input logic [3:0] op);
    case (op)
      OP_PUSH, OP_DUP, OP_OVER: return OFF_PUSH;
      OP_DROP, OP_NIP, OP_BIN:  return OFF_POP;
      default:                  return OFF_NONE;
    endcase
  endfunction

endpackage

// File: rtl/stack_seq_decode.sv
// stack_seq_decode: combinational translation of (state, registered word,
// depth, live T/N, saved T) into stack write controls and the error flag.
// Optional bounds checking is enabled by defining STACK_SEQ_BOUNDS_CHECK_EN.
module stack_seq_decode
  import stack_seq_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int W     = 16,
  parameter int DW    = $clog2(DEPTH) + 1
) (
  input  logic [1:0]    state_i,
  input  logic [3:0]    op_i,
  input  logic [W-1:0]  op_data_i,
  input  logic [DW-1:0] depth_i,
  input  logic [W-1:0]  stk_t_i,
  input  logic [W-1:0]  stk_n_i,
  input  logic [W-1:0]  save_t_i,
  output logic          t_write_o,
  output logic          n_write_o,
  output logic [W-1:0]  wdata_o,
  output logic [1:0]    offset_o,
  output logic          err_o
);

  logic viol;

`ifdef STACK_SEQ_BOUNDS_CHECK_EN
  assign viol = !op_legal(op_i)
             || (depth_i < DW'(op_min_depth(op_i)))
             || (op_grows(op_i) && (depth_i >= DW'(DEPTH)));
`else
  logic unused_depth;
  assign viol         = 1'b0;
  assign unused_depth = ^depth_i;
`endif

  // Errors only exist for the word currently executing.
  assign err_o = (state_i == ST_EXEC) && viol;

  // Stack controls per state/word; a violating word turns into a bubble.
  always_comb begin
    t_write_o = 1'b0;
    n_write_o = 1'b0;
    wdata_o   = '0;
    offset_o  = OFF_NONE;
    if (state_i == ST_EXEC && !viol) begin
      offset_o = op_offset(op_i);
      case (op_i)
        OP_PUSH, OP_REPL, OP_BIN: begin
          t_write_o = 1'b1;
          wdata_o   = op_data_i;
        end
        OP_DUP, OP_NIP: begin
          t_write_o = 1'b1;
          wdata_o   = stk_t_i;
        end
        OP_SWAP, OP_OVER: begin
          t_write_o = 1'b1;
          wdata_o   = stk_n_i;
        end
        default: ;
      endcase
    end else if (state_i == ST_SWAP2) begin
      n_write_o = 1'b1;
      wdata_o   = save_t_i;
    end
  end

endmodule

// File: rtl/stack_seq.sv
// stack_seq: accepts Forth stack words over valid/ready, sequences them into
// stack primitive controls (SWAP takes two cycles) and keeps a shadow depth.
// Optional bounds checking is enabled by defining STACK_SEQ_BOUNDS_CHECK_EN.
module stack_seq
  import stack_seq_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int W     = 16,
  parameter int DW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          op_valid_i,
  output logic          op_ready_o,
  input  logic [3:0]    op_i,
  input  logic [W-1:0]  op_data_i,
  output logic          done_o,
  output logic          err_o,
  output logic [DW-1:0] depth_o,
  input  logic [W-1:0]  stk_t_i,
  input  logic [W-1:0]  stk_n_i,
  output logic          stk_t_write_o,
  output logic          stk_n_write_o,
  output logic [W-1:0]  stk_wdata_o,
  output logic [1:0]    stk_offset_o
);

  logic [1:0]    state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  data_q, data_d;
  logic [W-1:0]  save_t_q, save_t_d;
  logic [DW-1:0] depth_q, depth_d;
  logic          accept;
  logic          swap_hold;
  logic          err;

  stack_seq_decode #(
    .DEPTH(DEPTH),
    .W    (W),
    .DW   (DW)
  ) u_decode (
    .state_i  (state_q),
    .op_i     (op_q),
    .op_data_i(data_q),
    .depth_i  (depth_q),
    .stk_t_i  (stk_t_i),
    .stk_n_i  (stk_n_i),
    .save_t_i (save_t_q),
    .t_write_o(stk_t_write_o),
    .n_write_o(stk_n_write_o),
    .wdata_o  (stk_wdata_o),
    .offset_o (stk_offset_o),
    .err_o    (err)
  );

  // A legal SWAP in EXEC still owes its N write, so it blocks new words.
  assign swap_hold  = (state_q == ST_EXEC) && (op_q == OP_SWAP) && !err;
  assign op_ready_o = (state_q == ST_IDLE) || (state_q == ST_SWAP2)
                   || ((state_q == ST_EXEC) && !swap_hold);
  assign accept     = op_valid_i && op_ready_o;
  assign done_o     = ((state_q == ST_EXEC) && !swap_hold) || (state_q == ST_SWAP2);
  assign err_o      = err;
  assign depth_o    = depth_q;

  // Next-state, operand capture, SWAP save and depth tracking.
  always_comb begin
    state_d  = state_q;
    op_d     = accept ? op_i : op_q;
    data_d   = accept ? op_data_i : data_q;
    save_t_d = ((state_q == ST_EXEC) && (op_q == OP_SWAP)) ? stk_t_i : save_t_q;
    depth_d  = depth_q + {{(DW-2){stk_offset_o[1]}}, stk_offset_o};
    case (state_q)
      ST_IDLE:  state_d = accept ? ST_EXEC : ST_IDLE;
      ST_EXEC:  state_d = swap_hold ? ST_SWAP2 : (accept ? ST_EXEC : ST_IDLE);
      ST_SWAP2: state_d = accept ? ST_EXEC : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any word in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      op_q     <= 4'(OP_NOP);
      data_q   <= '0;
      save_t_q <= '0;
      depth_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      data_q   <= data_d;
      save_t_q <= save_t_d;
      depth_q  <= depth_d;
    end
  end

endmodule

// File: doc/stack_seq.md
# stack_seq

Operation sequencer for the Forth processor's 16-bit data stack. Accepts one Forth stack word at a time (PUSH, DROP, DUP, SWAP, OVER, NIP, REPL, BIN) over a valid/ready handshake. Translates each word into the stack primitive controls: T write, N write, one shared write-data bus and a signed 2-bit top offset. Multi-step words are split across cycles, since the stack has only one write-data bus. Sits between the instruction decoder/ALU and the stack instance, and keeps a shadow depth count.

## Interface
- DEPTH, 256: stack entries; must match the stack instance.
- W, 16: data width.
- DW, $clog2(DEPTH)+1: depth counter width (9 at default).
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset, asynchronous, active-high; shared with the stack instance.
- OpValid  in  1  request valid.
- OpReady  out  1  sequencer can accept this cycle.
- Op  in  4  opcode: 0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 NIP, 7 REPL, 8 BIN; 9-15 illegal.
- OpData  in  W  literal for PUSH/REPL, ALU result for BIN; sampled at acceptance.
- Done  out  1  one-cycle pulse in the cycle a word commits.
- Err  out  1  bounds/illegal error, valid with Done (see Configuration).
- Depth  out  DW  shadow element count.
- StkT, StkN  in  W  current T/N from stack (combinational outputs).
- StkTWrite, StkNWrite  out  1  stack write enables.
- StkWData  out  W  stack write data.
- StkOffset  out  2  top delta: 01 = +1, 00 = 0, 11 = -1; 10 never driven.

## Operation
- States: IDLE, EXEC, SWAP2. Acceptance registers Op/OpData and moves to EXEC.
- Stack controls are decoded combinationally from state and registered op.
- WData uses live StkT/StkN in EXEC, so back-to-back words see prior commits.
- Per word in EXEC (offset, writes, data):
  - NOP: 0, none.
  - PUSH: +1, T, OpData.
  - DROP: -1, none.
  - DUP: +1, T, StkT.
  - OVER: +1, T, StkN.
  - NIP: -1, T, StkT.
  - REPL: 0, T, OpData.
  - BIN: -1, T, OpData.
- SWAP:
  - EXEC: offset 0, T write with StkN; StkT latched into a save register; go to SWAP2.
  - SWAP2: offset 0, N write with the saved T; Done.
- Other words: single cycle. Done is asserted in EXEC; next state is EXEC if a word is accepted, else IDLE.
- Depth changes by the committed offset at each commit edge.
- Illegal opcode executes as NOP.

## Timing
- Reset values: OpReady 1, Done 0, Err 0, Depth 0, StkTWrite 0, StkNWrite 0, StkWData 0, StkOffset 00, state IDLE.
- OpReady = IDLE, or EXEC with a non-SWAP word, or SWAP2.
- Accept at edge k → controls and Done valid during cycle k+1 → stack commits at edge k+1.
- SWAP: Done during cycle k+2.
- Throughput: 1 word/cycle for single-cycle words; SWAP occupies 2 cycles.
- Rst mid-word (including SWAP2): the word is abandoned and no Done is issued. Stack and Depth both return to 0, so they stay consistent.
- OpValid while OpReady=0: request is held, not accepted; Op/OpData must stay stable until accepted.

## Configuration
- STACK_SEQ_BOUNDS_CHECK_EN defined:
  - Minimum Depth per word: DROP/DUP/REPL 1; SWAP/OVER/NIP/BIN 2.
  - PUSH/DUP/OVER require Depth < DEPTH.
  - Violation or illegal opcode: no writes, offset 00, single cycle, Done=1 with Err=1, Depth unchanged.
- Undefined: Err tied 0; words issue unchecked; Depth wraps modulo 2^DW.

## Structure
- Package stack_seq_pkg holds:
  - opcode enum;
  - offset constants OFF_PUSH/OFF_NONE/OFF_POP;
  - per-opcode minimum-depth and growth functions.
- Sub-module stack_seq_decode: combinational (op, state, Depth, StkT, StkN, saved T) → stack controls and Err. The top level keeps the FSM, registers and Depth.

## Test plan
- Reset, then PUSH 0x1111, PUSH 0x2222 back-to-back → Done on 2 consecutive cycles; Depth=2; stack T=0x2222, N=0x1111.
- From [0x1111 0x2222], SWAP → 2 control cycles (T←0x1111, then N←0x2222); Done only in the second; T=0x1111, N=0x2222; OpReady low in the first cycle.
- From [0x0005 0x0007], DUP, OVER, NIP, BIN 0x000C back-to-back:
  - Depth steps 3, 4, 3, 2;
  - final T=0x000C, N=0x0005.
- With check enabled, DROP at Depth 0 → Err=1 with Done; StkOffset 00; Depth stays 0. Same for SWAP at Depth 1.
- With check enabled, PUSH 256 times, then one more PUSH → last PUSH Err=1; Depth=256. Opcode 0xF → Err=1, no write.
- Assert Rst during SWAP2 → no Done; all outputs at reset values immediately; next PUSH 0xABCD gives Depth 1, T=0xABCD.
